instruction_mem: RTL and testbench
==================================

# instruction_mem

Word-organised instruction memory for the 16-bit RISC core, read combinationally by the fetch stage using the byte-addressed program counter. Contents come from a built-in default image, in which each word holds its own word index. An asynchronous reset restores that image. A clocked write port lets the bench or a loader overwrite individual words.

## Interface
- Clock `clk`; reset `rst_n`, asynchronous, active-low. One clock domain.
- Parameters:
  - `ADDR_W`, default 16: width of byte addresses.
  - `DATA_W`, default 16: instruction width.
  - `DEPTH`, default 256: number of words, a power of two, at most 2^(ADDR_W-1).
- Ports:
  - `clk`  in  1  write clock.
  - `rst_n`  in  1  async active-low reset; restores the default image.
  - `address`  in  ADDR_W  byte address of the fetch.
  - `instruction`  out  DATA_W  word at `address`, combinational.
  - `addr_err`  out  1  high when the fetch word index is at or above DEPTH; combinational.
  - `we`  in  1  write enable, sampled on the rising edge of `clk`.
  - `waddr`  in  ADDR_W  byte address of the write.
  - `wdata`  in  DATA_W  write data.

## Operation
- Byte addressing, 2 bytes per word: word index = `address[ADDR_W-1:1]`.
  - `address[0]` is ignored, so odd addresses read the containing word.
- Default image: word i = i, truncated to DATA_W.
  - Byte 0x0004 reads 0x0002.
  - Byte 0x0030 reads 0x0018 (24).
- Fetch:
  - Index below DEPTH: `instruction` = mem[index] and `addr_err` = 0.
  - Index at or above DEPTH: `instruction` = 0 and `addr_err` = 1. Out-of-range addresses do not wrap.
- Write: on a rising `clk` edge with `we`=1 and `rst_n`=1, mem[`waddr[ADDR_W-1:1]`] <= `wdata`.
  - An out-of-range `waddr` is dropped; memory is unchanged.
  - `waddr[0]` is ignored.
- Reset: while `rst_n`=0, every word holds its default value.
  - Writes are ignored during reset.
  - Reads stay valid during reset and return the default image.

## Timing
- Fetch is purely combinational, with zero-cycle latency. `instruction` and `addr_err` follow `address` within the same cycle.
- A write takes effect at the clock edge.
- Read during write to the same word: `instruction` shows the old value before the edge and `wdata` after it. There is no write-through bypass.
- Assertion of `rst_n` takes effect immediately, with no clock needed. Outputs reflect the default image as soon as combinational settling completes.
- Reset asserted mid-write cycle: the reset wins and the write is lost.
- Deassertion of `rst_n` is synchronised externally. The first write is accepted on the first rising edge at which `rst_n`=1.
- Output values under reset, for address 0:
  - `instruction` = 0x0000, from the image.
  - `addr_err` = 0.

## Structure
- Shared package `riscv16_pkg` (core-wide) holds:
  - `INSTR_W` = 16 and `PC_W` = 16 constants.
  - typedef `instr_t` (logic [15:0]) and typedef `addr_t` (logic [15:0]).
- This block uses `instr_t` and `addr_t` for its ports.
- Storage is a register array of DEPTH x DATA_W with a generate-based reset image. It is not an inferred RAM, because reset must reload every word.
- One natural sub-module, `imem_addr_decode`: converts a byte address into a word index plus an in-range flag. It is instantiated twice, once for the fetch port and once for the write port.

## Test plan
- Reset released, `address`=0x0004 -> `instruction`=0x0002, `addr_err`=0.
- `address`=0x0030 -> 0x0018. `address`=0x0031 -> 0x0018, because bit 0 is ignored.
- Write `we`=1, `waddr`=0x0030, `wdata`=0xBEEF, with `address`=0x0030:
  - Before the edge, `instruction` reads 0x0018.
  - After the edge, it reads 0xBEEF.
  - `address`=0x0032 still reads 0x0019.
- Assert `rst_n`=0 asynchronously, between clock edges, after that write -> `instruction` at 0x0030 returns to 0x0018 with no clock edge. A write attempted while in reset is ignored.
- `address`=0x0200, word index 256 with DEPTH=256 -> `instruction`=0, `addr_err`=1. A write to `waddr`=0x0200 leaves word 0 at 0x0000.
- Sweep all 256 in-range words with no writes -> word i reads i at byte address 2i.

Source files
------------

// File: rtl/riscv16_pkg.sv
// Core-wide constants and types shared by the 16-bit RISC pipeline blocks.
package riscv16_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned PC_W    = 16;

   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [PC_W-1:0]    addr_t;

endpackage

// File: rtl/imem_addr_decode.sv
// Byte address to word index decode for instruction_mem.
// Bit 0 is dropped and any word index at or above DEPTH is flagged out of range.
module imem_addr_decode #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              in_range_o
);

   logic [ADDR_W-2:0] word;
   logic              unused_lsb;

   assign word       = addr_i[ADDR_W-1:1];
   assign unused_lsb = addr_i[0];
   assign idx_o      = word[IDX_W-1:0];

   // DEPTH is a power of two, so in range means every bit above the index is clear.
   generate
      if (IDX_W < ADDR_W - 1) begin : g_range_chk
         assign in_range_o = (word[ADDR_W-2:IDX_W] == '0);
      end else begin : g_full_range
         assign in_range_o = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/instruction_mem.sv
// Word-organised instruction memory: combinational fetch, clocked write port,
// and an asynchronous reset that reloads the identity image (word i = i).
module instruction_mem
   import riscv16_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 256
) (
   input  logic   clk,
   input  logic   rst_n,
   input  addr_t  address,
   output instr_t instruction,
   output logic   addr_err,
   input  logic   we,
   input  addr_t  waddr,
   input  instr_t wdata
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [IDX_W-1:0]  rd_idx;
   logic              rd_in_range;
   logic [IDX_W-1:0]  wr_idx;
   logic              wr_in_range;

   logic [DATA_W-1:0] reset_image [DEPTH];
   logic [DATA_W-1:0] mem_d       [DEPTH];
   logic [DATA_W-1:0] mem_q       [DEPTH];

   imem_addr_decode #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_rd_decode (
      .addr_i     (address),
      .idx_o      (rd_idx),
      .in_range_o (rd_in_range)
   );

   imem_addr_decode #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_wr_decode (
      .addr_i     (waddr),
      .idx_o      (wr_idx),
      .in_range_o (wr_in_range)
   );

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_reset_image
         assign reset_image[g] = DATA_W'(g);
      end
   endgenerate

   always_comb begin
      mem_d = mem_q;
      if (we && wr_in_range) begin
         mem_d[wr_idx] = wdata;
      end
   end

   // Register array rather than RAM: reset has to reload every word at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= reset_image;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      instruction = '0;
      addr_err    = ~rd_in_range;
      if (rd_in_range) begin
         instruction = mem_q[rd_idx];
      end
   end

endmodule

// File: tb/tb_instruction_mem.sv
// Directed self-checking bench for instruction_mem with hand-computed expectations.
module tb_instruction_mem;

   logic        clk;
   logic        rst_n;
   logic [15:0] address;
   logic [15:0] instruction;
   logic        addr_err;
   logic        we;
   logic [15:0] waddr;
   logic [15:0] wdata;

   int checks;
   int failures;

   instruction_mem #(
      .ADDR_W (16),
      .DATA_W (16),
      .DEPTH  (256)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .address     (address),
      .instruction (instruction),
      .addr_err    (addr_err),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      we       = 1'b0;
      address  = 16'h0000;
      waddr    = 16'h0000;
      wdata    = 16'h0000;

      // Outputs under reset at address 0
      #2;
      chk("rst_instr_a0", instruction, 16'h0000);
      chk("rst_err_a0", {15'b0, addr_err}, 16'h0000);

      @(negedge clk);
      rst_n   = 1'b1;
      address = 16'h0004;
      #1;
      chk("rd_0004", instruction, 16'h0002);
      chk("err_0004", {15'b0, addr_err}, 16'h0000);
      address = 16'h0030;
      #1;
      chk("rd_0030", instruction, 16'h0018);
      address = 16'h0031;
      #1;
      chk("rd_0031_odd", instruction, 16'h0018);

      // Write with read of the same word: old value before edge, new after
      @(negedge clk);
      we      = 1'b1;
      waddr   = 16'h0030;
      wdata   = 16'hBEEF;
      address = 16'h0030;
      #1;
      chk("rd_before_wr", instruction, 16'h0018);
      @(posedge clk);
      #1;
      chk("rd_after_wr", instruction, 16'hBEEF);
      we      = 1'b0;
      address = 16'h0032;
      #1;
      chk("rd_0032_neighbour", instruction, 16'h0019);

      // Async reset between edges, with a write pending that must be lost
      @(negedge clk);
      address = 16'h0030;
      we      = 1'b1;
      waddr   = 16'h0030;
      wdata   = 16'h1234;
      #2;
      rst_n   = 1'b0;
      #1;
      chk("async_rst_restore", instruction, 16'h0018);
      @(posedge clk);
      #1;
      chk("wr_in_reset_ignored", instruction, 16'h0018);

      // First write is accepted on the first edge with rst_n high
      @(negedge clk);
      rst_n   = 1'b1;
      we      = 1'b1;
      waddr   = 16'h0010;
      wdata   = 16'hA5A5;
      address = 16'h0010;
      #1;
      chk("rd_0010_pre", instruction, 16'h0008);
      @(posedge clk);
      #1;
      chk("first_wr_after_rst", instruction, 16'hA5A5);

      // Out-of-range fetch and dropped out-of-range write
      @(negedge clk);
      we      = 1'b0;
      address = 16'h0200;
      #1;
      chk("oor_instr_0200", instruction, 16'h0000);
      chk("oor_err_0200", {15'b0, addr_err}, 16'h0001);
      address = 16'hFFFF;
      #1;
      chk("oor_instr_ffff", instruction, 16'h0000);
      chk("oor_err_ffff", {15'b0, addr_err}, 16'h0001);
      address = 16'h01FF;
      #1;
      chk("last_word_odd", instruction, 16'h00FF);
      chk("last_word_err", {15'b0, addr_err}, 16'h0000);
      we      = 1'b1;
      waddr   = 16'h0200;
      wdata   = 16'h5555;
      @(posedge clk);
      #1;
      we      = 1'b0;
      address = 16'h0000;
      #1;
      chk("oor_wr_no_wrap_w0", instruction, 16'h0000);
      address = 16'h01FE;
      #1;
      chk("oor_wr_w255", instruction, 16'h00FF);

      // Odd write address hits the containing word
      @(negedge clk);
      we      = 1'b1;
      waddr   = 16'h000B;
      wdata   = 16'h7777;
      address = 16'h000A;
      @(posedge clk);
      #1;
      we = 1'b0;
      chk("odd_waddr_wr", instruction, 16'h7777);
      address = 16'h000C;
      #1;
      chk("odd_waddr_neighbour", instruction, 16'h0006);

      // Reset again, then sweep the whole default image
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         address = 16'(2 * i);
         #1;
         chk("sweep", instruction, 16'(i));
      end
      address = 16'h0000;
      #1;
      chk("sweep_end_err", {15'b0, addr_err}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
